// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared BCD digit width, bounds and digit type.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

    typedef logic [BCD_W-1:0] digit_t;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit
// Brief    : One BCD decade with load, increment and decrement, plus carry/borrow.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit
    import bcd_pkg::*;
(
    input  logic   clk,
    input  logic   rst_asyn,
    input  logic   inc,
    input  logic   dec,
    input  logic   load,
    input  digit_t load_digit,
    output digit_t digit,
    output logic   carry,
    output logic   borrow
);

    // Carry/borrow are combinational so the whole chain settles in one cycle.
    assign carry  = inc && (digit == BCD_MAX);
    assign borrow = dec && (digit == BCD_MIN);

    always_ff @(posedge clk or negedge rst_asyn) begin
        if (!rst_asyn) begin
            digit <= BCD_MIN;
        end else if (load) begin
            digit <= (load_digit > BCD_MAX) ? BCD_MIN : load_digit;
        end else if (inc) begin
            digit <= (digit >= BCD_MAX) ? BCD_MIN : digit + 4'd1;
        end else if (dec) begin
            digit <= (digit == BCD_MIN || digit > BCD_MAX) ? BCD_MAX : digit - 4'd1;
        end
    end

endmodule : bcd_digit
`default_nettype wire

// File: rtl/bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_updown_counter
// Brief    : Cascaded DIGITS-decade BCD up/down counter with load and tc pulse.
//            Define BCD_SATURATE_EN to saturate at the bounds instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_asyn,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   Q_out,
    output logic                  tc,
    output logic                  load_err
);

    digit_t      digits [DIGITS];
    logic [DIGITS:0] inc_chain;
    logic [DIGITS:0] dec_chain;

    logic step_up;
    logic step_dn;
    logic hi_max;
    logic hi_min;
    logic bad_digit;
    logic tc_next;

    assign step_up = en && up && !load;
    assign step_dn = en && !up && !load;

    // hi_* look only at digits above digit 0; they detect the bound one step away.
    always_comb begin
        hi_max    = 1'b1;
        hi_min    = 1'b1;
        bad_digit = 1'b0;
        for (int i = 1; i < DIGITS; i++) begin
            hi_max = hi_max && (digits[i] == BCD_MAX);
            hi_min = hi_min && (digits[i] == BCD_MIN);
        end
        for (int i = 0; i < DIGITS; i++) begin
            bad_digit = bad_digit || (load_val[BCD_W*i +: BCD_W] > BCD_MAX);
        end
    end

`ifdef BCD_SATURATE_EN
    logic all_max;
    logic all_min;

    assign all_max      = hi_max && (digits[0] == BCD_MAX);
    assign all_min      = hi_min && (digits[0] == BCD_MIN);
    assign inc_chain[0] = step_up && !all_max;
    assign dec_chain[0] = step_dn && !all_min;
    assign tc_next      = (step_up && hi_max && (digits[0] == BCD_MAX - 4'd1)) ||
                          (step_dn && hi_min && (digits[0] == BCD_MIN + 4'd1));
`else
    assign inc_chain[0] = step_up;
    assign dec_chain[0] = step_dn;
    assign tc_next      = inc_chain[DIGITS] || dec_chain[DIGITS];
`endif

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .clk        (clk),
                .rst_asyn   (rst_asyn),
                .inc        (inc_chain[g]),
                .dec        (dec_chain[g]),
                .load       (load),
                .load_digit (load_val[BCD_W*g +: BCD_W]),
                .digit      (digits[g]),
                .carry      (inc_chain[g+1]),
                .borrow     (dec_chain[g+1])
            );
            assign Q_out[BCD_W*g +: BCD_W] = digits[g];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_asyn) begin
        if (!rst_asyn) begin
            tc       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tc       <= tc_next;
            load_err <= load && bad_digit;
        end
    end

endmodule : bcd_updown_counter
`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_updown_counter
// Brief    : Scoreboard bench; integer reference model vs. the BCD counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_updown_counter;

    localparam int DIGITS = 4;
    localparam int MAXV   = 9999;

`ifdef BCD_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [4*DIGITS-1:0] q;
        logic                tc;
        logic                lerr;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_asyn;
    logic                en;
    logic                up;
    logic                load;
    logic [4*DIGITS-1:0] load_val;
    logic [4*DIGITS-1:0] Q_out;
    logic                tc;
    logic                load_err;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   model_v    = 0;

    bcd_updown_counter #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst_asyn (rst_asyn),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .Q_out    (Q_out),
        .tc       (tc),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int x;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [4*DIGITS-1:0] b);
        int v;
        int w;
        logic [3:0] nib;
        v = 0;
        w = 1;
        for (int d = 0; d < DIGITS; d++) begin
            nib = b[4*d +: 4];
            v   = v + ((nib > 4'd9) ? 0 : int'(nib)) * w;
            w   = w * 10;
        end
        return v;
    endfunction

    function automatic bit has_bad(input logic [4*DIGITS-1:0] b);
        logic [3:0] nib;
        for (int d = 0; d < DIGITS; d++) begin
            nib = b[4*d +: 4];
            if (nib > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Drive one clock of stimulus and push what the next edge must produce.
    task automatic cyc(input bit e, input bit u, input bit l, input logic [4*DIGITS-1:0] lv);
        exp_t x;
        @(negedge clk);
        en = e; up = u; load = l; load_val = lv;
        x.tc = 1'b0;
        x.lerr = 1'b0;
        if (l) begin
            model_v = from_bcd(lv);
            x.lerr  = has_bad(lv);
        end else if (e && u) begin
            if (model_v == MAXV) begin
                if (!SAT) begin model_v = 0; x.tc = 1'b1; end
            end else begin
                model_v++;
                x.tc = SAT && (model_v == MAXV);
            end
        end else if (e && !u) begin
            if (model_v == 0) begin
                if (!SAT) begin model_v = MAXV; x.tc = 1'b1; end
            end else begin
                model_v--;
                x.tc = SAT && (model_v == 0);
            end
        end
        x.q = to_bcd(model_v);
        sbq.push_back(x);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic mid_reset();
        exp_t z;
        z = '0;
        @(negedge clk);
        en = 1'b0; load = 1'b0;
        #2 rst_asyn = 1'b0;
        #1;
        check("async_q", 32'(Q_out), 32'h0);
        check("async_tc", 32'(tc), 32'h0);
        check("async_lerr", 32'(load_err), 32'h0);
        model_v = 0;
        sbq.push_back(z);
        @(negedge clk);
        rst_asyn = 1'b1;
        sbq.push_back(z);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("q_out", 32'(Q_out), 32'(e.q));
            check("tc", 32'(tc), 32'(e.tc));
            check("load_err", 32'(load_err), 32'(e.lerr));
        end
    end

    initial begin
        logic [4*DIGITS-1:0] lv;
        rst_asyn = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        #3;
        check("reset_q", 32'(Q_out), 32'h0);
        check("reset_tc", 32'(tc), 32'h0);
        @(negedge clk);
        rst_asyn = 1'b1;
        sbq.push_back('0);

        for (int i = 0; i < 11; i++) cyc(1, 1, 0, '0);
        cyc(0, 1, 1, 16'h9998);
        cyc(1, 1, 0, '0);
        cyc(1, 1, 0, '0);
        cyc(1, 1, 0, '0);

        mid_reset();
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);

        cyc(0, 0, 1, 16'h12A4);
        cyc(0, 0, 0, '0);
        cyc(0, 0, 1, 16'h5678);
        cyc(1, 1, 1, 16'h0437);
        cyc(1, 0, 0, '0);
        cyc(1, 1, 0, '0);
        cyc(0, 1, 1, 16'h0437);
        mid_reset();
        cyc(1, 1, 0, '0);

        cyc(0, 1, 1, 16'h9999);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, '0);
        cyc(0, 0, 1, 16'h0001);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, '0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 15))
                0: lv = 16'h9999;
                1: lv = 16'h9998;
                2: lv = 16'h0001;
                3: lv = 16'h0000;
                default: begin
                    for (int d = 0; d < DIGITS; d++)
                        lv[4*d +: 4] = ($urandom_range(0, 7) == 0) ?
                                       4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                end
            endcase
            cyc(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 9) == 0), lv);
            if ($urandom_range(0, 199) == 0) mid_reset();
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 32'(sbq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_bcd_updown_counter
`default_nettype wire

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 4, is the number of cascaded BCD decades; the legal range is 1..8.
REQ-002 Port clk, input, 1 bit: the single rising-edge clock.
REQ-003 Port rst_asyn, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 Port en, input, 1 bit: count enable.
REQ-005 Port up, input, 1 bit: direction, where 1 means count up and 0 means count down.
REQ-006 Port load, input, 1 bit: synchronous parallel load.
REQ-007 Port load_val, input, 4*DIGITS bits: the value to load, packed BCD with digit 0 in bits [3:0].
REQ-008 Port Q_out, output, 4*DIGITS bits: the count value, packed BCD with digit 0 in bits [3:0].
REQ-009 Port tc, output, 1 bit: terminal-count pulse.
REQ-010 Port load_err, output, 1 bit: a pulse flagging an invalid BCD digit in load_val.

Function
REQ-011 All state SHALL update only on the rising edge of clk, except for reset.
REQ-012 Priority SHALL be: reset first, then load, then en; when none of these is active, Q_out holds.
REQ-013 Load: when load=1 at an edge, each digit of Q_out SHALL take its load_val digit, and any digit greater than 9 SHALL be loaded as 0.
REQ-014 load_err SHALL be 1 for exactly the one cycle after a load edge in which any load_val digit was greater than 9, and 0 otherwise.
REQ-015 Up count: when en=1, up=1 and load=0, digit 0 SHALL increment; a digit at 9 SHALL become 0 and pass a carry to the next digit.
REQ-016 Down count: when en=1, up=0 and load=0, digit 0 SHALL decrement; a digit at 0 SHALL become 9 and pass a borrow to the next digit.
REQ-017 The carry/borrow ripple across all DIGITS SHALL resolve within the same cycle, so the count has 1-cycle latency from the en edge to Q_out.
REQ-018 Wrap-around: up from all-9s SHALL give all-0s, and down from all-0s SHALL give all-9s.
REQ-019 tc SHALL be 1 for the one cycle following the edge at which a wrap occurred (or a bound was reached, see REQ-024), and 0 otherwise.
REQ-020 Changing up while en=1 SHALL take effect at the next edge, with no idle cycle inserted.
REQ-021 Q_out SHALL never hold a digit value greater than 9.

Reset
REQ-022 When rst_asyn=0, Q_out, tc and load_err SHALL go to 0 immediately, regardless of clk.
REQ-023 Reset asserted mid-count SHALL abort the count; after release, counting SHALL resume from 0 at the first edge with en=1.

Configuration
REQ-024 With the macro BCD_SATURATE_EN defined, the counter SHALL saturate instead of wrapping: up at all-9s holds all-9s, down at all-0s holds all-0s, and tc pulses on the edge that first reaches the bound (not again while held there).
REQ-025 Without BCD_SATURATE_EN, the wrap behaviour of REQ-018 and REQ-019 SHALL apply.

Structure
REQ-026 A shared package bcd_pkg SHALL hold BCD_W=4, BCD_MAX=4'd9, BCD_MIN=4'd0 and the digit typedef.
REQ-027 A sub-module bcd_digit SHALL hold one decade (inputs: inc, dec, load, load digit; outputs: digit, carry, borrow).
REQ-028 The top level SHALL instantiate DIGITS copies of bcd_digit through a generate loop, chaining carry and borrow between them.

Verification
REQ-029 Reset then up-count: release reset, en=1, up=1 for 10 cycles -> Q_out goes 0000..0009, then 0010; tc stays 0.
REQ-030 Up wrap: load 9998, up for 2 cycles -> 9999, then 0000; tc=1 only in the cycle showing 0000.
REQ-031 Down wrap: from reset, up=0, en=1 for 1 cycle -> 9999 and tc=1; 1 more cycle -> 9998 and tc=0.
REQ-032 Invalid load: load_val=16'h12A4 -> Q_out=1204 and load_err=1 for 1 cycle; load_val=16'h5678 -> load_err=0.
REQ-033 Priority and reset mid-operation: load=1 and en=1 together -> load wins; rst_asyn=0 between clock edges at count 0437 -> Q_out=0000 before the next edge.
REQ-034 Saturation build (BCD_SATURATE_EN defined): load 9999, up for 3 cycles -> 9999 held, tc=0 throughout; load 0001, down for 2 cycles -> 0000 with tc=1 once, then held.
